alarm_trigger: RTL
==================

Name: alarm_trigger

Overview:
- Downstream consumer of the current-time counter and alarm-time counter BCD digits.
- Compares the two times and runs the alarm state machine: arm/disarm, ring, snooze, auto-timeout.
- Drives a buzzer square wave and status flags for the seven-segment/VGA display stage.
- Sits in the top level between the time-keeping section and the output section.

Parameters:
RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-return to ARMED (1..1023)
SNOOZE_S, 300, snooze duration in seconds (1..1023)
BUZZ_DIV, 50000, clk cycles per buzzer half-period (≥1)
MAX_SNOOZES, 3, snoozes allowed per alarm event (0..3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sec_tick  input  1  one-clk pulse per elapsed second, in clk domain
settime  input  1  level; high while the user sets the current time
arm_toggle  input  1  one-clk pulse; toggles armed/disarmed
snooze_req  input  1  one-clk pulse; snooze request
stop_req  input  1  one-clk pulse; silences the alarm
cur_digits  input  24  current time {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}, 4-bit BCD each
alm_digits  input  24  alarm time, same packing
armed  output  1  high in any state except DISARMED
ringing  output  1  high in RINGING
snoozing  output  1  high in SNOOZE
buzzer  output  1  square wave while ringing, else 0
snooze_left  output  10  remaining snooze seconds; 0 outside SNOOZE
snooze_count  output  2  snoozes used in the current alarm event

Behaviour:
- Reset (reset low, asynchronous): state=DISARMED; all outputs 0; match_d=0; ring_cnt=0; div_cnt=0.
- match = (cur_digits == alm_digits), combinational. match_d is registered every clk, regardless of state or settime.
- trigger = match & ~match_d & ~settime. Only a rising edge of match fires the alarm. A match already present when settime falls does not fire.
- Priority within one cycle: arm_toggle > stop_req > snooze_req > timeout/sec_tick > trigger.
- DISARMED:
  - arm_toggle -> ARMED.
  - Everything else ignored.
- ARMED:
  - arm_toggle -> DISARMED.
  - trigger -> RINGING; ring_cnt=0; snooze_count=0.
- RINGING:
  - arm_toggle -> DISARMED; snooze_count=0.
  - stop_req -> ARMED; snooze_count=0.
  - snooze_req with snooze_count<MAX_SNOOZES -> SNOOZE; snooze_left=SNOOZE_S; snooze_count+1.
  - snooze_req with snooze_count==MAX_SNOOZES is ignored; ringing continues.
  - sec_tick with ring_cnt==RING_TIMEOUT_S-1 -> ARMED; snooze_count=0. Otherwise sec_tick increments ring_cnt.
  - trigger ignored.
- SNOOZE:
  - arm_toggle -> DISARMED; snooze_left=0; snooze_count=0.
  - stop_req -> ARMED; snooze_left=0; snooze_count=0.
  - sec_tick with snooze_left==1 -> RINGING; ring_cnt=0; snooze_left=0. Otherwise sec_tick decrements snooze_left.
  - snooze_req and trigger ignored.
- Buzzer:
  - div_cnt and buzzer are cleared on every entry to RINGING.
  - In RINGING, div_cnt counts 0..BUZZ_DIV-1; buzzer toggles on wrap. Period is 2*BUZZ_DIV clks.
  - Buzzer is forced to 0 in the same cycle the state leaves RINGING.
- Latency:
  - All outputs are registered.
  - ringing rises on the first clk edge after match becomes true.
  - Flag changes after a pulse input appear on the next edge.
- Width rules: ring_cnt and snooze_left are 10-bit; snooze_count saturates at MAX_SNOOZES and never wraps.
- Reset mid-ring or mid-snooze returns to DISARMED immediately and asynchronously, with buzzer 0.

Test Plan:
Bench parameters: RING_TIMEOUT_S=4, SNOOZE_S=3, BUZZ_DIV=4, MAX_SNOOZES=2.
1. Reset low, drive arm_toggle -> all outputs 0, state stays DISARMED; release reset, pulse arm_toggle -> armed=1.
2. Armed, cur_digits steps from 12:00:59 to alm 12:01:00 -> ringing=1 one clk later; buzzer toggles every 4 clks; 4 sec_ticks later ringing=0, armed=1.
3. Ringing, pulse snooze_req -> snoozing=1, snooze_left=3, snooze_count=1; ticks give 2, 1, then ringing=1 with snooze_left=0; second snooze_req -> snooze_count=2; third snooze_req while ringing is ignored.
4. Ringing, assert stop_req and snooze_req in the same cycle -> stop wins: armed=1, ringing=0, snoozing=0, snooze_count=0.
5. Set settime=1, then drive cur==alm -> no ring; drop settime while still matching -> no ring; change cur away and back to alm -> ringing=1.
6. Mid-snooze (snooze_left=2), pulse reset low for 3 ns between clk edges -> all outputs 0 immediately; after release, matching time does not ring until arm_toggle is pulsed.

Source files
------------

// File: rtl/alarm_trigger.sv
// Alarm compare and control FSM: arm/disarm, ring, snooze, auto-timeout, buzzer.
// All outputs come straight from registers.
module alarm_trigger #(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned BUZZ_DIV       = 50000,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        settime,
  input  logic        arm_toggle,
  input  logic        snooze_req,
  input  logic        stop_req,
  input  logic [23:0] cur_digits,
  input  logic [23:0] alm_digits,
  output logic        armed,
  output logic        ringing,
  output logic        snoozing,
  output logic        buzzer,
  output logic [9:0]  snooze_left,
  output logic [1:0]  snooze_count
);

  localparam int unsigned DivW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [DivW-1:0] DivLast    = DivW'(BUZZ_DIV - 1);
  localparam logic [9:0]      RingLast   = 10'(RING_TIMEOUT_S - 1);
  localparam logic [9:0]      SnoozeInit = 10'(SNOOZE_S);
  localparam logic [1:0]      MaxSnooze  = 2'(MAX_SNOOZES);

  typedef enum logic [1:0] {StDisarmed, StArmed, StRinging, StSnooze} state_e;

  state_e          state_q, state_d;
  logic            match, match_q, trigger;
  logic [9:0]      ring_cnt_q, ring_cnt_d;
  logic [9:0]      snooze_left_q, snooze_left_d;
  logic [1:0]      snooze_count_q, snooze_count_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            buzzer_q, buzzer_d;

  assign match   = (cur_digits == alm_digits);
  // Only a fresh match fires; a match left standing after settime drops does not.
  assign trigger = match & ~match_q & ~settime;

  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snooze_left_d  = snooze_left_q;
    snooze_count_d = snooze_count_q;
    case (state_q)
      StDisarmed: begin
        if (arm_toggle) state_d = StArmed;
      end
      StArmed: begin
        if (arm_toggle) begin
          state_d = StDisarmed;
        end else if (trigger) begin
          state_d        = StRinging;
          ring_cnt_d     = '0;
          snooze_count_d = '0;
        end
      end
      StRinging: begin
        if (arm_toggle) begin
          state_d        = StDisarmed;
          snooze_count_d = '0;
        end else if (stop_req) begin
          state_d        = StArmed;
          snooze_count_d = '0;
        end else if (snooze_req && (snooze_count_q < MaxSnooze)) begin
          state_d        = StSnooze;
          snooze_left_d  = SnoozeInit;
          snooze_count_d = snooze_count_q + 2'd1;
        end else if (sec_tick) begin
          if (ring_cnt_q == RingLast) begin
            state_d        = StArmed;
            snooze_count_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q + 10'd1;
          end
        end
      end
      StSnooze: begin
        if (arm_toggle || stop_req) begin
          state_d        = arm_toggle ? StDisarmed : StArmed;
          snooze_left_d  = '0;
          snooze_count_d = '0;
        end else if (sec_tick) begin
          if (snooze_left_q == 10'd1) begin
            state_d       = StRinging;
            ring_cnt_d    = '0;
            snooze_left_d = '0;
          end else begin
            snooze_left_d = snooze_left_q - 10'd1;
          end
        end
      end
      default: state_d = StDisarmed;
    endcase
  end

  // Buzzer restarts from a known phase on every entry and is silenced on exit.
  always_comb begin
    div_cnt_d = '0;
    buzzer_d  = 1'b0;
    if (state_d == StRinging && state_q == StRinging) begin
      if (div_cnt_q == DivLast) begin
        buzzer_d = ~buzzer_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
        buzzer_d  = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StDisarmed;
      match_q        <= 1'b0;
      ring_cnt_q     <= '0;
      snooze_left_q  <= '0;
      snooze_count_q <= '0;
      div_cnt_q      <= '0;
      buzzer_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      match_q        <= match;
      ring_cnt_q     <= ring_cnt_d;
      snooze_left_q  <= snooze_left_d;
      snooze_count_q <= snooze_count_d;
      div_cnt_q      <= div_cnt_d;
      buzzer_q       <= buzzer_d;
    end
  end

  assign armed        = (state_q != StDisarmed);
  assign ringing      = (state_q == StRinging);
  assign snoozing     = (state_q == StSnooze);
  assign buzzer       = buzzer_q;
  assign snooze_left  = snooze_left_q;
  assign snooze_count = snooze_count_q;

endmodule
